mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- Multi-cycle successor of the single-cycle MIPS datapath. It owns the PC, IR, register file, ALU, extender and all inter-stage registers.
- It talks to instruction and data memory through req/ack handshakes, so memories of any latency can be attached.
- Decode stays in an external combinational controller. The block exports op/funct and consumes the decoded control bundle.
- The ALU is widened to 3-bit ALUOp with logical/shift/compare modes, and the block adds retire/trace ports for the bench.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- RF_NUM, 32, number of implemented GPRs (power of two, 8..32). Indices >= RF_NUM read 0; writes to them are dropped.
- MEM_AW, 32, byte-address width driven on imem_addr/dmem_addr. Upper bits are truncated.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  MEM_AW  fetch byte address (= PC)
- imem_rdata  in  32  instruction word, valid with imem_ack
- imem_ack  in  1  fetch completion
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  MEM_AW  data byte address (ALUOut)
- dmem_wdata  out  32  store data (B register)
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  data completion
- op  out  6  IR[31:26]
- funct  out  6  IR[5:0]
- WRsel  in  2  00 rt, 01 rd, 10 $31
- WDsel  in  2  00 ALUOut, 01 MDR, 10 PC+4
- RFWr, EXTOp, Bsel, DMWr, DMRd, Br, LUIsel, Jal, Jr, J  in  1 each  decoded controls
- ALUOp  in  3  000 add, 001 sub, 010 or, 011 and, 100 xor, 101 slt (signed), 110 sll, 111 srl
- pc  out  32  current PC
- retire  out  1  one-cycle pulse in WB
- wb_we  out  1  RF write occurs this cycle
- wb_reg  out  5  destination register
- wb_data  out  32  written data

Behaviour:
- Reset state: FETCH. pc = RESET_PC, IR = 0, all GPRs = 0. All req, retire and wb_* outputs are 0.
- Reset mid-transaction: any req is dropped on the next edge. A late ack is ignored.
- FETCH:
  - imem_req = 1 and held stable until imem_ack.
  - On ack, IR <= imem_rdata and go to DEC.
  - Minimum latency is 1 cycle (ack seen the cycle after the req edge, or the same cycle).
- DEC:
  - op/funct are valid from IR; the controls are sampled combinationally from DEC to WB.
  - A <= RF[rs], B <= RF[rt], Ext <= ext(imm).
  - Ext rules: EXTOp 1 = sign-extend, 0 = zero-extend; LUIsel gives {imm,16'b0}.
- EXE:
  - ALUOut <= ALU(A, Bsel ? Ext : B). For sll/srl the operand is B and the shift amount is IR[10:6].
  - Zero flag is latched.
  - Next state is MEM if DMRd|DMWr, else WB.
- MEM:
  - dmem_req = 1 with dmem_we = DMWr; address and data are held until dmem_ack.
  - On ack for a load, MDR <= dmem_rdata. Then go to WB.
  - Both DMRd and DMWr set is illegal: the store wins.
- WB:
  - RF write when RFWr and the destination != 0. wb_we/wb_reg/wb_data mirror the write; retire = 1.
  - PC update priority: Jr → A; J|Jal → {pc4[31:28], IR[25:0], 2'b00}; Br & zero → pc4 + (sext(imm) << 2); else pc4.
  - Return to FETCH.
- Arithmetic: 32-bit modulo, no overflow traps. slt writes 1/0.
- $0 always reads 0.
- Ack arriving while the matching req = 0 is ignored.
- CPI: ALU/branch/jump 4 + imem wait; load/store 5 + imem wait + dmem wait.

Decomposition:
- Package mc_pkg holds:
  - state enum FETCH/DEC/EXE/MEM/WB;
  - ALUOp codes and WRsel/WDsel codes;
  - REG_RA = 5'd31.
- One sub-module, mc_regfile: 2R/1W, synchronous write, asynchronous read, parameter RF_NUM.
- ALU and extender stay inline.

Test Plan:
- Reset, then one fetch with ack delayed 3 cycles → imem_req held 4 cycles, imem_addr = 32'h3000 throughout, then DEC.
- ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2 → wb_data 0x00001234, 0xABCD0000, 0xABCD1234; retire every 4 cycles with single-cycle memory.
- sw $3,8($0), then lw $4,8($0) with dmem_ack after 2 cycles → dmem_addr 8, dmem_we 1 then 0; $4 = 0xABCD1234; each retires at 5 + wait cycles.
- beq $1,$1,-1 at 0x3010 → next pc 0x3010. bne-style not-taken (beq $1,$2) → pc 0x3014.
- jal 0x0C00 at 0x3020 → $31 = 0x3024, pc = 0x3000. Then jr $31 → pc 0x3024. addu $0,$1,$1 → wb_we 0, $0 reads 0.
- Assert reset during MEM with dmem_req high → req low next cycle, pc = RESET_PC. A stray dmem_ack afterwards causes no RF write.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS datapath: FSM states, ALU/mux
// select encodings and the link register index.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    DEC   = 3'd1,
    EXE   = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_AND = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    WR_RT = 2'b00,
    WR_RD = 2'b01,
    WR_RA = 2'b10
  } wrsel_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_MDR = 2'b01,
    WD_PC4 = 2'b10
  } wdsel_e;

  localparam logic [4:0] REG_RA = 5'd31;

  function automatic logic [31:0] ext16(input logic [15:0] imm,
                                        input logic        sign,
                                        input logic        lui);
    if (lui)       return {imm, 16'h0000};
    else if (sign) return {{16{imm[15]}}, imm};
    else           return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Instruction and data memory req/ack bus; the datapath is the master.
interface mc_datapath_if #(
    parameter int MEM_AW = 32
) ();
    logic              imem_req;
    logic [MEM_AW-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [MEM_AW-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mc_regfile.sv
// GPR file: two asynchronous read ports, one synchronous write port.
// Indices at or above RF_NUM read as zero and ignore writes; $0 is hardwired.
module mc_regfile #(
    parameter int RF_NUM = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    localparam int IW = $clog2(RF_NUM);

    logic [31:0] regs [RF_NUM];

    function automatic logic implemented(input logic [4:0] a);
        return (a >> IW) == 5'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RF_NUM; i++) regs[i] <= '0;
        end else if (we && (waddr != 5'd0) && implemented(waddr)) begin
            regs[waddr[IW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if ((raddr1 != 5'd0) && implemented(raddr1)) rdata1 = regs[raddr1[IW-1:0]];
        if ((raddr2 != 5'd0) && implemented(raddr2)) rdata2 = regs[raddr2[IW-1:0]];
    end
endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath: FETCH/DEC/EXE/MEM/WB over req/ack memories,
// with decode left to an external combinational controller.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          RF_NUM   = 32,
    parameter int          MEM_AW   = 32
) (
    input  logic         clk,
    input  logic         reset,
    mc_datapath_if.master bus,
    output logic [5:0]   op,
    output logic [5:0]   funct,
    input  logic [1:0]   WRsel,
    input  logic [1:0]   WDsel,
    input  logic         RFWr,
    input  logic         EXTOp,
    input  logic         Bsel,
    input  logic         DMWr,
    input  logic         DMRd,
    input  logic         Br,
    input  logic         LUIsel,
    input  logic         Jal,
    input  logic         Jr,
    input  logic         J,
    input  logic [2:0]   ALUOp,
    output logic [31:0]  pc,
    output logic         retire,
    output logic         wb_we,
    output logic [4:0]   wb_reg,
    output logic [31:0]  wb_data
);
    state_e      state;
    logic [31:0] ir, a_r, b_r, ext_r, aluout, mdr;
    logic        zero_r;
    logic        imem_req_r, dmem_req_r, dmem_we_r;

    logic [31:0] pc4, rf_rd1, rf_rd2, alu_b, alu_y, npc, wd;
    logic [4:0]  wa;
    logic        rf_we;

    wire [4:0]  rs  = ir[25:21];
    wire [4:0]  rt  = ir[20:16];
    wire [4:0]  rd  = ir[15:11];
    wire [15:0] imm = ir[15:0];

    assign pc4   = pc + 32'd4;
    assign op    = ir[31:26];
    assign funct = ir[5:0];

    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = MEM_AW'(pc);
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = MEM_AW'(aluout);
    assign bus.dmem_wdata = b_r;

    mc_regfile #(.RF_NUM(RF_NUM)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (wa),
        .wdata  (wd),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // Shifts take B as the operand and IR[10:6] as the amount, independent of Bsel.
    always_comb begin
        alu_b = Bsel ? ext_r : b_r;
        case (aluop_e'(ALUOp))
            ALU_ADD: alu_y = a_r + alu_b;
            ALU_SUB: alu_y = a_r - alu_b;
            ALU_OR:  alu_y = a_r | alu_b;
            ALU_AND: alu_y = a_r & alu_b;
            ALU_XOR: alu_y = a_r ^ alu_b;
            ALU_SLT: alu_y = {31'b0, ($signed(a_r) < $signed(alu_b))};
            ALU_SLL: alu_y = b_r << ir[10:6];
            ALU_SRL: alu_y = b_r >> ir[10:6];
            default: alu_y = a_r + alu_b;
        endcase
    end

    always_comb begin
        case (wrsel_e'(WRsel))
            WR_RD:   wa = rd;
            WR_RA:   wa = REG_RA;
            default: wa = rt;
        endcase
        case (wdsel_e'(WDsel))
            WD_MDR:  wd = mdr;
            WD_PC4:  wd = pc4;
            default: wd = aluout;
        endcase
        rf_we = (state == WB) && RFWr && (wa != 5'd0);
    end

    always_comb begin
        if (Jr)               npc = a_r;
        else if (J || Jal)    npc = {pc4[31:28], ir[25:0], 2'b00};
        else if (Br && zero_r) npc = pc4 + {{14{imm[15]}}, imm, 2'b00};
        else                  npc = pc4;
    end

    assign retire  = (state == WB);
    assign wb_we   = rf_we;
    assign wb_reg  = rf_we ? wa : '0;
    assign wb_data = rf_we ? wd : '0;

    // The first FETCH cycle after reset only raises imem_req; WB re-enters
    // FETCH with the request already up so back-to-back retires stay 4 apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            a_r        <= '0;
            b_r        <= '0;
            ext_r      <= '0;
            aluout     <= '0;
            mdr        <= '0;
            zero_r     <= 1'b0;
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req_r) begin
                        imem_req_r <= 1'b1;
                    end else if (bus.imem_ack) begin
                        ir         <= bus.imem_rdata;
                        imem_req_r <= 1'b0;
                        state      <= DEC;
                    end
                end
                DEC: begin
                    a_r   <= rf_rd1;
                    b_r   <= rf_rd2;
                    ext_r <= ext16(imm, EXTOp, LUIsel);
                    state <= EXE;
                end
                EXE: begin
                    aluout <= alu_y;
                    zero_r <= (alu_y == '0);
                    if (DMRd || DMWr) begin
                        dmem_req_r <= 1'b1;
                        dmem_we_r  <= DMWr;
                        state      <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        if (!dmem_we_r) mdr <= bus.dmem_rdata;
                        dmem_req_r <= 1'b0;
                        dmem_we_r  <= 1'b0;
                        state      <= WB;
                    end
                end
                WB: begin
                    pc         <= npc;
                    imem_req_r <= 1'b1;
                    state      <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: bench-side decoder and memories, with a
// scoreboard of expected retire records checked as each instruction completes.
module tb_mc_datapath;
    import mc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_datapath_if #(.MEM_AW(32)) bus ();

    logic [5:0]  op, funct;
    logic [1:0]  WRsel, WDsel;
    logic        RFWr, EXTOp, Bsel, DMWr, DMRd, Br, LUIsel, Jal, Jr, J;
    logic [2:0]  ALUOp;
    logic [31:0] pc;
    logic        retire, wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    mc_datapath #(.RESET_PC(32'h0000_3000), .RF_NUM(32), .MEM_AW(32)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .op(op), .funct(funct), .WRsel(WRsel), .WDsel(WDsel),
        .RFWr(RFWr), .EXTOp(EXTOp), .Bsel(Bsel), .DMWr(DMWr), .DMRd(DMRd),
        .Br(Br), .LUIsel(LUIsel), .Jal(Jal), .Jr(Jr), .J(J), .ALUOp(ALUOp),
        .pc(pc), .retire(retire), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    // External controller for the instruction subset used below.
    always_comb begin
        WRsel = WR_RT; WDsel = WD_ALU; ALUOp = ALU_ADD;
        RFWr = 0; EXTOp = 0; Bsel = 0; DMWr = 0; DMRd = 0;
        Br = 0; LUIsel = 0; Jal = 0; Jr = 0; J = 0;
        case (op)
            6'h00: begin
                RFWr = 1; WRsel = WR_RD;
                case (funct)
                    6'h21: ALUOp = ALU_ADD;
                    6'h23: ALUOp = ALU_SUB;
                    6'h25: ALUOp = ALU_OR;
                    6'h24: ALUOp = ALU_AND;
                    6'h26: ALUOp = ALU_XOR;
                    6'h2A: ALUOp = ALU_SLT;
                    6'h00: ALUOp = ALU_SLL;
                    6'h02: ALUOp = ALU_SRL;
                    6'h08: begin RFWr = 0; Jr = 1; end
                    default: RFWr = 0;
                endcase
            end
            6'h0D: begin RFWr = 1; Bsel = 1; ALUOp = ALU_OR; end
            6'h0F: begin RFWr = 1; Bsel = 1; LUIsel = 1; ALUOp = ALU_OR; end
            6'h23: begin RFWr = 1; Bsel = 1; EXTOp = 1; DMRd = 1; WDsel = WD_MDR; end
            6'h2B: begin Bsel = 1; EXTOp = 1; DMWr = 1; end
            6'h04: begin Br = 1; ALUOp = ALU_SUB; end
            6'h02: J = 1;
            6'h03: begin Jal = 1; RFWr = 1; WRsel = WR_RA; WDsel = WD_PC4; end
            default: ;
        endcase
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [31:0] dm [16];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] rs, rt, input logic [15:0] im);
        return {o, rs, rt, im};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] o, input logic [25:0] t);
        return {o, t};
    endfunction

    // Serve one instruction end to end; expected retire latency is CPI-1
    // counted from the first cycle imem_req is seen high.
    task automatic exec(input logic [31:0] pc_exp, input logic [31:0] instr,
                        input int iw, input int dw,
                        input logic is_mem, input logic is_st,
                        input logic [31:0] daddr, input logic [31:0] sdata,
                        input logic we, input logic [4:0] rg, input logic [31:0] data);
        exp_t e, got;
        int n;
        int unsigned t0;
        e.we = we; e.rg = rg; e.data = data;
        e.lat = is_mem ? 4 + iw + dw : 3 + iw;
        sb.push_back(e);

        n = 0;
        while (!bus.imem_req && n < 50) begin @(negedge clk); n++; end
        chk("imem_req", {31'b0, bus.imem_req}, 32'd1);
        t0 = cyc;
        chk("imem_addr", bus.imem_addr, pc_exp);
        for (int i = 0; i < iw; i++) begin
            @(negedge clk);
            chk("imem_req_hold", {31'b0, bus.imem_req}, 32'd1);
            chk("imem_addr_hold", bus.imem_addr, pc_exp);
        end
        bus.imem_rdata = instr;
        bus.imem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        chk("imem_req_drop", {31'b0, bus.imem_req}, 32'd0);
        chk("op", {26'b0, op}, {26'b0, instr[31:26]});
        chk("funct", {26'b0, funct}, {26'b0, instr[5:0]});

        if (is_mem) begin
            n = 0;
            @(negedge clk);
            while (!bus.dmem_req && n < 50) begin @(negedge clk); n++; end
            chk("dmem_req", {31'b0, bus.dmem_req}, 32'd1);
            chk("dmem_we", {31'b0, bus.dmem_we}, {31'b0, is_st});
            chk("dmem_addr", bus.dmem_addr, daddr);
            if (is_st) chk("dmem_wdata", bus.dmem_wdata, sdata);
            repeat (dw) @(negedge clk);
            chk("dmem_addr_hold", bus.dmem_addr, daddr);
            bus.dmem_rdata = dm[daddr[5:2]];
            if (is_st) dm[daddr[5:2]] = sdata;
            bus.dmem_ack = 1'b1;
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
        end

        n = 0;
        @(negedge clk);
        while (!retire && n < 50) begin @(negedge clk); n++; end
        chk("retire", {31'b0, retire}, 32'd1);
        got = sb.pop_front();
        chk("retire_latency", cyc - t0, got.lat);
        chk("wb_we", {31'b0, wb_we}, {31'b0, got.we});
        if (got.we) begin
            chk("wb_reg", {27'b0, wb_reg}, {27'b0, got.rg});
            chk("wb_data", wb_data, got.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) dm[i] = '0;
        reset = 1'b1;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(posedge clk); #1;
        chk("reset_pc", pc, 32'h0000_3000);
        chk("reset_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("reset_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
        chk("reset_retire", {31'b0, retire}, 32'd0);
        chk("reset_wb_we", {31'b0, wb_we}, 32'd0);
        chk("reset_op", {26'b0, op}, 32'd0);
        reset = 1'b0;

        exec(32'h3000, enc_i(6'h0D, 0, 1, 16'h1234), 3, 0, 0, 0, 0, 0, 1, 5'd1, 32'h0000_1234);
        exec(32'h3004, enc_i(6'h0F, 0, 2, 16'hABCD), 0, 0, 0, 0, 0, 0, 1, 5'd2, 32'hABCD_0000);
        exec(32'h3008, enc_r(1, 2, 3, 0, 6'h21),      0, 0, 0, 0, 0, 0, 1, 5'd3, 32'hABCD_1234);
        exec(32'h300C, enc_i(6'h2B, 0, 3, 16'h0008), 0, 2, 1, 1, 32'd8, 32'hABCD_1234, 0, 5'd0, 32'd0);
        exec(32'h3010, enc_i(6'h04, 1, 1, 16'hFFFF), 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0);
        exec(32'h3010, enc_i(6'h23, 0, 4, 16'h0008), 0, 2, 1, 0, 32'd8, 32'd0, 1, 5'd4, 32'hABCD_1234);
        exec(32'h3014, enc_i(6'h04, 1, 2, 16'h0005), 0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0);
        exec(32'h3018, enc_r(2, 1, 5, 0, 6'h2A),      0, 0, 0, 0, 0, 0, 1, 5'd5, 32'd1);
        exec(32'h301C, enc_r(0, 1, 6, 4, 6'h00),      0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h0001_2340);
        exec(32'h3020, enc_j(6'h03, 26'h0000C00),    0, 0, 0, 0, 0, 0, 1, 5'd31, 32'h0000_3024);
        exec(32'h3000, enc_r(31, 0, 0, 0, 6'h08),     0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0);
        exec(32'h3024, enc_r(1, 1, 0, 0, 6'h21),      0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0);
        exec(32'h3028, enc_r(0, 4, 7, 0, 6'h21),      0, 0, 0, 0, 0, 0, 1, 5'd7, 32'hABCD_1234);
        exec(32'h302C, enc_r(1, 2, 8, 0, 6'h23),      0, 0, 0, 0, 0, 0, 1, 5'd8, 32'h5433_1234);
        exec(32'h3030, enc_r(3, 1, 9, 0, 6'h26),      0, 0, 0, 0, 0, 0, 1, 5'd9, 32'hABCD_0000);
        exec(32'h3034, enc_r(0, 2, 10, 16, 6'h02),    1, 0, 0, 0, 0, 0, 1, 5'd10, 32'h0000_ABCD);

        // Reset while a load sits in MEM, then a stray data ack.
        n = 0;
        while (!bus.imem_req && n < 50) begin @(negedge clk); n++; end
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rst_imem_addr", bus.imem_addr, 32'h3038);
        bus.imem_rdata = enc_i(6'h23, 0, 11, 16'h0008);
        bus.imem_ack   = 1'b1;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.dmem_req && n < 50) begin @(negedge clk); n++; end
        chk("rst_dmem_req_before", {31'b0, bus.dmem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_dmem_req_after", {31'b0, bus.dmem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_imem_req_after", {31'b0, bus.imem_req}, 32'd0);
        reset = 1'b0;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        bus.dmem_ack   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_wb_we", {31'b0, wb_we}, 32'd0);
            chk("stray_retire", {31'b0, retire}, 32'd0);
        end
        bus.dmem_ack = 1'b0;

        // GPRs were cleared by the reset, so $3 + $1 is zero.
        exec(32'h3000, enc_r(3, 1, 12, 0, 6'h21), 0, 0, 0, 0, 0, 0, 1, 5'd12, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
